// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one UART transmitter among NUM_REQ requesters.
// Optional macro UART_TX_ARB_TIMEOUT_EN adds a WAIT-state watchdog that drives timeout_err.
module uart_tx_arb #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         done,
    output logic                       tx_valid,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_start,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err
);

    localparam int GID_W = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || GAP_CYCLES < 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("uart_tx_arb: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_GAP
    } state_e;

    state_e              state_q;
    logic [GID_W-1:0]    last_grant_q;
    logic [GID_W-1:0]    grant_id_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                tx_valid_q;
    logic                tx_start_q;
    logic                busy_q;
    logic [GAP_W-1:0]    gap_cnt_q;

    logic [GID_W-1:0]    win_d;
    logic                any_req_d;
    logic [DATA_W-1:0]   slot_data [NUM_REQ];

    // Priority chain: offset gi+1 from last_grant; the nearest asserted requester wins.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rr
        logic [GID_W:0]   sum;
        logic [GID_W-1:0] cand;
        logic             hit;
        logic             found;
        logic [GID_W-1:0] pick;

        assign sum  = {1'b0, last_grant_q} + (GID_W+1)'(gi + 1);
        assign cand = (sum >= (GID_W+1)'(NUM_REQ)) ? GID_W'(sum - (GID_W+1)'(NUM_REQ))
                                                   : sum[GID_W-1:0];
        assign hit  = req[cand];
        assign slot_data[gi] = req_data[gi*DATA_W +: DATA_W];

        if (gi == 0) begin : g_first
            assign found = hit;
            assign pick  = cand;
        end else begin : g_next
            assign found = g_rr[gi-1].found | hit;
            assign pick  = g_rr[gi-1].found ? g_rr[gi-1].pick : cand;
        end
    end

    assign win_d     = g_rr[NUM_REQ-1].pick;
    assign any_req_d = g_rr[NUM_REQ-1].found;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WD_W-1:0] wdog_q;
    logic            timeout_err_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= GID_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            tx_data_q    <= '0;
            ack_q        <= '0;
            done_q       <= '0;
            tx_valid_q   <= 1'b0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            gap_cnt_q    <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            ack_q      <= '0;
            done_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_start_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        state_q    <= S_LOAD;
                        busy_q     <= 1'b1;
                        grant_id_q <= win_d;
                        tx_data_q  <= slot_data[win_d];
                        ack_q      <= NUM_REQ'(1) << win_d;
                        tx_valid_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q    <= S_START;
                    tx_start_q <= 1'b1;
                end
                S_START: begin
                    state_q <= S_WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    wdog_q  <= '0;
`endif
                end
                S_WAIT: begin
                    if (tx_done) begin
                        done_q       <= NUM_REQ'(1) << grant_id_q;
                        last_grant_q <= grant_id_q;
                        if (GAP_CYCLES == 0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= '0;
                        end
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    // A stalled transmitter still advances the rotation, so nobody starves.
                    else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        timeout_err_q <= 1'b1;
                        last_grant_q  <= grant_id_q;
                        if (GAP_CYCLES == 0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= '0;
                        end
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign done     = done_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: vector table, directed corner sequences, then random traffic
// against a transaction-level reference model.
module tb_uart_tx_arb;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int GAP = 2;
    localparam int TO  = 16;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [31:0] TBL_DATA = 32'h4433_22A5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .NUM_REQ    (NR),
        .DATA_W     (DW),
        .GAP_CYCLES (GAP),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .done       (done),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_done    (tx_done),
        .busy       (busy),
        .grant_id   (grant_id),
        .timeout_err(timeout_err)
    );

    logic [21:0] dut_vec;
    assign dut_vec = {ack, done, tx_valid, tx_start, busy, timeout_err, grant_id, tx_data};

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: frame life-cycle tracked as a phase plus countdowns.
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_START = 2, PH_WAIT = 3, PH_GAP = 4;
    int         m_phase;
    int         m_gap;
    int         m_wait;
    logic [1:0] m_last;
    logic [1:0] m_gid;
    logic [7:0] m_data;
    logic [3:0] exp_ack, exp_done;
    logic       exp_valid, exp_start, exp_busy, exp_to;

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int k = NR; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % NR);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    function automatic void model_reset();
        m_phase = PH_IDLE; m_gap = 0; m_wait = 0;
        m_last = 2'(NR - 1); m_gid = 2'd0; m_data = 8'h00;
        exp_ack = 4'h0; exp_done = 4'h0;
        exp_valid = 1'b0; exp_start = 1'b0; exp_busy = 1'b0; exp_to = 1'b0;
    endfunction

    function automatic void model_finish_frame();
        m_last = m_gid;
        if (GAP == 0) m_phase = PH_IDLE;
        else begin
            m_phase = PH_GAP;
            m_gap   = GAP;
        end
    endfunction

    function automatic void model_edge();
        logic [1:0] w;
        exp_ack = 4'h0; exp_done = 4'h0;
        exp_valid = 1'b0; exp_start = 1'b0; exp_to = 1'b0;
        case (m_phase)
            PH_IDLE: if (req != 4'h0) begin
                w = rr_pick(req, m_last);
                m_gid  = w;
                m_data = 8'(req_data >> {w, 3'b000});
                exp_ack[w] = 1'b1;
                exp_valid  = 1'b1;
                m_phase    = PH_LOAD;
            end
            PH_LOAD: begin
                exp_start = 1'b1;
                m_phase   = PH_START;
            end
            PH_START: begin
                m_phase = PH_WAIT;
                m_wait  = 0;
            end
            PH_WAIT: begin
                if (tx_done) begin
                    exp_done[m_gid] = 1'b1;
                    model_finish_frame();
                end else if (TO_EN) begin
                    m_wait++;
                    if (m_wait == TO) begin
                        exp_to = 1'b1;
                        model_finish_frame();
                    end
                end
            end
            default: begin
                m_gap--;
                if (m_gap == 0) m_phase = PH_IDLE;
            end
        endcase
        exp_busy = (m_phase != PH_IDLE);
    endfunction

    function automatic logic [21:0] model_vec();
        return {exp_ack, exp_done, exp_valid, exp_start, exp_busy, exp_to, m_gid, m_data};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    // Inputs are set before the call; the model sees them as sampled at the coming edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        txd;
        logic [21:0] exp;
    } row_t;

    row_t tbl[$];

    function automatic logic [21:0] mk(input logic [3:0] a, input logic [3:0] d, input logic v,
                                       input logic s, input logic b, input logic [1:0] g,
                                       input logic [7:0] dat);
        return {a, d, v, s, b, 1'b0, g, dat};
    endfunction

    function automatic void add_row(input logic [3:0] r, input logic t, input logic [21:0] e);
        row_t row;
        row.req = r; row.txd = t; row.exp = e;
        tbl.push_back(row);
    endfunction

    function automatic void add_frame(input logic [3:0] r0, input logic [3:0] rr,
                                      input logic [1:0] w, input logic early);
        logic [3:0] oh;
        logic [7:0] dv;
        oh = 4'b0001 << w;
        dv = 8'(TBL_DATA >> {w, 3'b000});
        add_row(r0, 1'b0,  mk(oh,   4'h0, 1'b1, 1'b0, 1'b1, w, dv));
        add_row(rr, early, mk(4'h0, 4'h0, 1'b0, 1'b1, 1'b1, w, dv));
        add_row(rr, early, mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, w, dv));
        add_row(rr, 1'b0,  mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, w, dv));
        add_row(rr, 1'b1,  mk(4'h0, oh,   1'b0, 1'b0, 1'b1, w, dv));
        add_row(rr, 1'b0,  mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, w, dv));
        add_row(rr, 1'b0,  mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, w, dv));
    endfunction

    task automatic frame(input string tag, input logic [3:0] r, input logic [3:0] r_rest,
                         input logic [1:0] w);
        logic [3:0] oh;
        logic [7:0] dv;
        oh = 4'b0001 << w;
        dv = 8'(req_data >> {w, 3'b000});
        req = r; tx_done = 1'b0;
        step();
        check({tag, "_ack"}, 32'({ack, tx_valid, grant_id, tx_data}), 32'({oh, 1'b1, w, dv}));
        req = r_rest;
        step();
        check({tag, "_start"}, 32'({tx_start, ack, tx_valid}), 32'({1'b1, 4'h0, 1'b0}));
        step();
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check({tag, "_done"}, 32'({done, timeout_err}), 32'({oh, 1'b0}));
        step();
        step();
        check({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    function automatic logic [31:0] expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, limit 1000000 time units");
        $fatal(1);
    end

    initial begin
        logic [3:0] drop, raise, ackclr, nreq;
        logic [31:0] hold;

        reset_n = 1'b1; req = 4'h0; req_data = TBL_DATA; tx_done = 1'b0;
        model_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(dut_vec), 32'(0));
        reset_n = 1'b1;

        // Single frame with early tx_done pulses, then four round-robin frames on req=1111.
        add_frame(4'b0001, 4'b0000, 2'd0, 1'b1);
        add_frame(4'b1111, 4'b1111, 2'd1, 1'b0);
        add_frame(4'b1111, 4'b1111, 2'd2, 1'b0);
        add_frame(4'b1111, 4'b1111, 2'd3, 1'b0);
        add_frame(4'b1111, 4'b1111, 2'd0, 1'b0);
        foreach (tbl[i]) begin
            req = tbl[i].req;
            tx_done = tbl[i].txd;
            step();
            check($sformatf("table[%0d]", i), 32'(dut_vec), 32'(tbl[i].exp));
        end
        req = 4'h0; tx_done = 1'b0;

        // last_grant becomes 2, then 0101 must grant 0 before 2.
        frame("rr_set2", 4'b0100, 4'b0000, 2'd2);
        frame("rr_0101a", 4'b0101, 4'b0101, 2'd0);
        frame("rr_0101b", 4'b0101, 4'b0000, 2'd2);

        // Asynchronous reset in the middle of WAIT.
        req = 4'b1000;
        step();
        req = 4'h0;
        step();
        step();
        check("wait_busy", 32'(busy), 32'(1));
        reset_n = 1'b0;
        #2;
        check("rst_in_wait", 32'(dut_vec), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        frame("post_rst", 4'b1000, 4'b0000, 2'd3);

`ifdef UART_TX_ARB_TIMEOUT_EN
        req = 4'b0010;
        step();
        check("to_ack", 32'(ack), 32'(4'b0010));
        req = 4'h0;
        step();
        step();
        for (int n = 1; n <= TO; n++) begin
            step();
            check($sformatf("to_wait%0d", n), 32'({timeout_err, done, busy}),
                  32'({(n == TO) ? 1'b1 : 1'b0, 4'h0, 1'b1}));
        end
        step();
        step();
        check("to_idle", 32'(busy), 32'(0));
        frame("to_next", 4'b0111, 4'b0000, 2'd2);
`endif

        // Random traffic: requests rise, withdraw, or clear after ack; tx_done pulses anywhere.
        reset_n = 1'b0;
        req = 4'h0; tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            drop   = 4'($urandom) & 4'($urandom) & 4'($urandom);
            raise  = 4'($urandom) & 4'($urandom);
            ackclr = exp_ack & 4'($urandom);
            nreq   = (req & ~drop & ~ackclr) | (~req & raise);
            hold   = expand(req & nreq);
            req_data = (req_data & hold) | ($urandom & ~hold);
            req      = nreq;
            tx_done  = ($urandom_range(0, 5) == 0);
            step();
            check($sformatf("rand[%0d]", c), 32'(dut_vec), 32'(model_vec()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one UART transmitter (range 2..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the frame payload width.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2, meaning the idle cycles inserted between frames (0 = none).
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1024, meaning the watchdog limit in the WAIT state.
REQ-005 The block SHALL have port clk  in  1  single system clock; all state on rising edge.
REQ-006 The block SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port req  in  NUM_REQ  per-requester frame request, level.
REQ-008 The block SHALL have port req_data  in  NUM_REQ*DATA_W  flattened payloads; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port ack  out  NUM_REQ  one-cycle pulse: payload captured.
REQ-010 The block SHALL have port done  out  NUM_REQ  one-cycle pulse: frame fully transmitted.
REQ-011 The block SHALL have port tx_valid  out  1  load strobe to the transmitter shift register.
REQ-012 The block SHALL have port tx_data  out  DATA_W  captured payload, stable from LOAD until next LOAD.
REQ-013 The block SHALL have port tx_start  out  1  one-cycle start-of-transmission strobe.
REQ-014 The block SHALL have port tx_done  in  1  transmitter end-of-frame pulse (stop bit sent).
REQ-015 The block SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-016 The block SHALL have port grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
REQ-017 The block SHALL have port timeout_err  out  1  one-cycle watchdog pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, START, WAIT and GAP; all outputs SHALL be registered.
REQ-019 In IDLE with any req bit high at edge k, the block SHALL select a winner by round-robin: search from last_grant+1 upward, wrapping modulo NUM_REQ.
REQ-020 At edge k the block SHALL enter LOAD, capture req_data[winner] into tx_data, set grant_id=winner, and assert ack[winner] and tx_valid for exactly the following cycle.
REQ-021 At edge k+1 the block SHALL enter START with tx_start=1 for one cycle; at edge k+2 it SHALL enter WAIT.
REQ-022 tx_done SHALL be ignored in IDLE, LOAD, START and GAP.
REQ-023 In WAIT, on tx_done the block SHALL pulse done[grant_id] for one cycle, set last_grant=grant_id, and enter GAP (or IDLE if GAP_CYCLES=0).
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles and then enter IDLE; req changes during GAP SHALL be ignored.
REQ-025 A requester SHALL hold req and its req_data stable until ack; deasserting req earlier SHALL withdraw the request with no side effect.
REQ-026 Bits set simultaneously in req SHALL resolve by round-robin only; no requester SHALL wait more than NUM_REQ-1 frames.
REQ-027 At most one bit of ack, and at most one bit of done, SHALL be high in any cycle.

Reset
REQ-028 Assertion of reset_n low SHALL immediately force IDLE and drive ack, done, tx_valid, tx_start, busy, timeout_err, tx_data and grant_id to 0, including in the middle of a frame.
REQ-029 After reset, last_grant SHALL equal NUM_REQ-1, so requester 0 has first priority.

Configuration
REQ-030 With macro UART_TX_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT; if it reaches TIMEOUT_CYC without tx_done, the block SHALL pulse timeout_err, not pulse done, set last_grant=grant_id, and enter GAP.
REQ-031 Without UART_TX_ARB_TIMEOUT_EN, WAIT SHALL persist until tx_done, timeout_err SHALL be tied 0, and no counter logic SHALL be synthesized.

Verification
REQ-032 Bench: req=4'b0001, data0=8'hA5 -> ack[0] one cycle later with tx_valid=1 and tx_data=8'hA5; tx_start on the next cycle; done[0] one cycle after tx_done.
REQ-033 Bench: req=4'b1111 held continuously -> grant order 0,1,2,3,0, with GAP_CYCLES=2 idle cycles between done and the next ack.
REQ-034 Bench: req=4'b0101 with last_grant=2 -> requester 0 is granted, then requester 2.
REQ-035 Bench: reset_n low during WAIT -> all outputs 0 in the same cycle; after release, req=4'b1000 is granted normally.
REQ-036 Bench with UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: tx_done withheld -> timeout_err pulses 16 cycles into WAIT, no done pulse, next requester served.
REQ-037 Bench: tx_done pulsed in START -> ignored; done is asserted only after a tx_done arriving in WAIT.
